// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM/op types and word geometry for wait_state_ram
package ram_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} ram_state_t;
   typedef enum logic {OP_READ, OP_WRITE} ram_op_t;
   localparam int WORD_BYTES = 4;
endpackage

// File: rtl/word_ram_array.sv
// word_ram_array: single-port word array, synchronous write, registered read
//   clk, reset_n : clock, sync active-low reset (clears rdata only)
//   we, re       : write / read enables
//   index        : word index
//   wdata, rdata : write data in, registered read data out (held when re low)
module word_ram_array
   import ram_pkg::*;
#(
   parameter int INDEX_WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       we,
   input  logic                       re,
   input  logic [INDEX_WIDTH-1:0]     index,
   input  logic [8*WORD_BYTES-1:0]    wdata,
   output logic [8*WORD_BYTES-1:0]    rdata
);
   logic [8*WORD_BYTES-1:0] mem [2**INDEX_WIDTH];
   always_ff @(posedge clk)
      if (we) mem[index] <= wdata;
   always_ff @(posedge clk)
      if (!reset_n) rdata <= '0;
      else if (re) rdata <= mem[index];
endmodule

// File: rtl/wait_state_ram.sv
// wait_state_ram: byte-addressed word RAM with wait states, ready strobe and illegal-access error
//   clk, reset_n           : clock, sync active-low reset
//   cs, we, oe             : chip select, write request, read request
//   address, data_input    : byte address, little-endian write word
//   data_output            : registered read data
//   ready, error           : one-cycle completion strobe, illegal-access strobe (with ready)
module wait_state_ram
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        we,
   input  logic        oe,
   input  logic [31:0] address,
   input  logic [31:0] data_input,
   output logic [31:0] data_output,
   output logic        ready,
   output logic        error
);
   localparam int AL = $clog2(WORD_BYTES);
   localparam int IW = ADDR_WIDTH - AL;
   ram_state_t    state, state_nx;
   ram_op_t       op;
   logic [3:0]    wcnt;
   logic          bad, req, take, access, wr_en, rd_en;
   logic [IW-1:0] idx;
   logic [31:0]   wdata;
   // DONE's closing edge also samples a new request, so back-to-back
   // accesses repeat every WAIT_STATES+2 cycles.
   always_comb begin
      req      = cs && (we || oe);
      take     = (state == IDLE || state == DONE) && req;
      access   = state == BUSY && wcnt == '0;
      state_nx = take ? BUSY : access ? DONE : state == BUSY ? BUSY : IDLE;
      ready    = state == DONE;
      error    = state == DONE && bad;
      wr_en    = reset_n && access && !bad && op == OP_WRITE;
      rd_en    = access && !bad && op == OP_READ;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         wcnt  <= '0;
         op    <= OP_READ;
         bad   <= 1'b0;
         idx   <= '0;
         wdata <= '0;
      end else begin
         state <= state_nx;
         if (take) begin
            op    <= we ? OP_WRITE : OP_READ;
            bad   <= (we && oe) || address[AL-1:0] != '0 || (address >> ADDR_WIDTH) != '0;
            idx   <= address[ADDR_WIDTH-1:AL];
            wdata <= data_input;
            wcnt  <= 4'(WAIT_STATES);
         end else if (state == BUSY && wcnt != '0) begin
            wcnt <= wcnt - 4'd1;
         end
      end
   end
   word_ram_array #(.INDEX_WIDTH(IW)) u_array (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_en),
      .re      (rd_en),
      .index   (idx),
      .wdata   (wdata),
      .rdata   (data_output)
   );
endmodule

// File: tb/tb_wait_state_ram.sv
// tb_wait_state_ram: scoreboard bench for wait_state_ram (WAIT_STATES=2 and WAIT_STATES=0 instances)
module tb_wait_state_ram;
   typedef struct {int cyc; logic err; logic [31:0] dout;} exp_t;
   logic clk = 0, reset_n = 0;
   logic cs = 0, we = 0, oe = 0, cs0 = 0, we0 = 0, oe0 = 0;
   logic [31:0] address = 0, data_input = 0, address0 = 0, data_input0 = 0;
   logic [31:0] data_output, data_output0;
   logic ready, error, ready0, error0;
   int cyc = 0, passed = 0, total = 0;
   exp_t q2[$], q0[$];
   logic [31:0] mem_m [logic [31:0]];
   logic [31:0] dout_m = 0;
   wait_state_ram #(.ADDR_WIDTH(12), .WAIT_STATES(2)) u2 (
      .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .oe(oe), .address(address),
      .data_input(data_input), .data_output(data_output), .ready(ready), .error(error));
   wait_state_ram #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u0 (
      .clk(clk), .reset_n(reset_n), .cs(cs0), .we(we0), .oe(oe0), .address(address0),
      .data_input(data_input0), .data_output(data_output0), .ready(ready0), .error(error0));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (ready || error) begin
         if (q2.size() == 0) chk("ws2 unexpected ready", {30'b0, ready, error}, 32'h0);
         else begin
            e = q2.pop_front();
            chk("ws2 ready", ready, 1);
            chk("ws2 ready cycle", cyc, e.cyc);
            chk("ws2 error", error, e.err);
            chk("ws2 data_output", data_output, e.dout);
         end
      end
      if (ready0 || error0) begin
         if (q0.size() == 0) chk("ws0 unexpected ready", {30'b0, ready0, error0}, 32'h0);
         else begin
            e = q0.pop_front();
            chk("ws0 ready", ready0, 1);
            chk("ws0 ready cycle", cyc, e.cyc);
            chk("ws0 error", error0, e.err);
            chk("ws0 data_output", data_output0, e.dout);
         end
      end
   end
   // Call at a negedge; returns at the negedge where ready is seen, inputs still driven.
   task automatic issue(input logic w, input logic o, input logic [31:0] a, input logic [31:0] d,
                        input logic hold);
      exp_t e;
      logic b;
      bit seen;
      cs = 1; we = w; oe = o; address = a; data_input = d;
      b = (w && o) || a[1:0] != 2'b0 || a >= 32'h1000;
      if (!b && w) mem_m[a] = d;
      if (!b && o) dout_m = mem_m[a];
      e.cyc = cyc + 4; e.err = b; e.dout = dout_m;
      q2.push_back(e);
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (k == 0 && !hold) cs = 0;
         seen = ready;
      end
      chk("ws2 ready arrives", {31'b0, seen}, 1);
   endtask
   task automatic idle(input int n);
      cs = 0; we = 0; oe = 0;
      repeat (n) @(negedge clk);
   endtask
   initial begin
      exp_t e;
      repeat (3) @(negedge clk);
      chk("reset ready", ready, 0);
      chk("reset error", error, 0);
      chk("reset data_output", data_output, 0);
      reset_n = 1;
      @(negedge clk);
      issue(1, 0, 0, 32'hE3A0_0001, 1); idle(1);
      issue(0, 1, 0, 0, 1); idle(2);
      issue(1, 0, 0, 32'h1111_0000, 1);
      issue(1, 0, 4, 32'h2222_0004, 1);
      issue(1, 0, 8, 32'h3333_0008, 1);
      issue(0, 1, 0, 0, 1);
      issue(0, 1, 4, 0, 1);
      issue(0, 1, 8, 0, 1); idle(2);
      issue(1, 1, 0, 32'hFFFF_FFFF, 1); idle(1);
      issue(1, 0, 2, 32'h5555_5555, 1); idle(1);
      issue(1, 0, 32'h0000_1000, 32'h6666_6666, 1); idle(1);
      issue(0, 1, 0, 0, 1); idle(2);
      issue(1, 0, 12, 32'hDEAD_BEEF, 0); idle(1);
      issue(0, 1, 12, 0, 1); idle(2);
      issue(1, 0, 16, 32'h0, 1); idle(1);
      cs = 1; we = 1; oe = 0; address = 16; data_input = 32'h1234_5678;
      @(negedge clk); cs = 0; we = 0;
      @(negedge clk); reset_n = 0;
      @(negedge clk);
      chk("mid-reset ready", ready, 0);
      chk("mid-reset error", error, 0);
      chk("mid-reset data_output", data_output, 0);
      reset_n = 1; dout_m = 0;
      idle(6);
      issue(0, 1, 16, 0, 1); idle(2);
      cs0 = 1; we0 = 1; oe0 = 0; address0 = 0; data_input0 = 32'hCAFE_F00D;
      e.cyc = cyc + 2; e.err = 0; e.dout = 0; q0.push_back(e);
      @(negedge clk); cs0 = 0; we0 = 0;
      repeat (3) @(negedge clk);
      cs0 = 1; oe0 = 1;
      for (int i = 1; i <= 4; i++) begin
         e.cyc = cyc + 2 * i; e.err = 0; e.dout = 32'hCAFE_F00D; q0.push_back(e);
      end
      repeat (8) @(negedge clk);
      cs0 = 0; oe0 = 0;
      repeat (6) @(negedge clk);
      chk("ws2 scoreboard drained", q2.size(), 0);
      chk("ws0 scoreboard drained", q0.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
